// File: rtl/track_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// track_arb_pkg
// Shared types and constants for the track tile-map BRAM arbiter.
//   src_t        : 2-bit source ID carried alongside each BRAM read
//   TRACK_ADDR_W : tile-map address width (128x128 tiles)
//   TILE_W       : tile code width
// ---------------------------------------------------------------------------
package track_arb_pkg;

   localparam int TRACK_ADDR_W = 14;
   localparam int TILE_W       = 4;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_VID,
      SRC_PLAYER,
      SRC_OPP
   } src_t;

endpackage

// File: rtl/track_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// track_mem_arbiter_if
// Bundles the three requester channels and the BRAM port of the arbiter.
//   vid_*  : video pixel fetch, fixed priority, always accepted
//   p_*    : player kart surface lookup, req/ready handshake
//   o_*    : opponent kart surface lookup, req/ready handshake
//   mem_*  : registered BRAM address out, BRAM read data in
// Modports: slave = arbiter side, master = requesters + BRAM side.
// ---------------------------------------------------------------------------
interface track_mem_arbiter_if
   import track_arb_pkg::*;
#(
   parameter int ADDR_W = TRACK_ADDR_W,
   parameter int DATA_W = TILE_W
);

   logic              vid_req_in;
   logic [ADDR_W-1:0] vid_addr_in;
   logic              vid_valid_out;
   logic [DATA_W-1:0] vid_data_out;

   logic              p_req_in;
   logic [ADDR_W-1:0] p_addr_in;
   logic              p_ready_out;
   logic              p_valid_out;
   logic [DATA_W-1:0] p_data_out;

   logic              o_req_in;
   logic [ADDR_W-1:0] o_addr_in;
   logic              o_ready_out;
   logic              o_valid_out;
   logic [DATA_W-1:0] o_data_out;

   logic [ADDR_W-1:0] mem_addr_out;
   logic [DATA_W-1:0] mem_data_in;

   modport slave (
      input  vid_req_in, vid_addr_in, p_req_in, p_addr_in,
             o_req_in, o_addr_in, mem_data_in,
      output vid_valid_out, vid_data_out,
             p_ready_out, p_valid_out, p_data_out,
             o_ready_out, o_valid_out, o_data_out,
             mem_addr_out
   );

   modport master (
      output vid_req_in, vid_addr_in, p_req_in, p_addr_in,
             o_req_in, o_addr_in, mem_data_in,
      input  vid_valid_out, vid_data_out,
             p_ready_out, p_valid_out, p_data_out,
             o_ready_out, o_valid_out, o_data_out,
             mem_addr_out
   );

endinterface

// File: rtl/track_mem_arbiter_tag_pipe.sv
// ---------------------------------------------------------------------------
// arb_tag_pipe
// Shift register of source tags that travels alongside the BRAM read so the
// returning data can be steered to whoever issued it.
//   clk, rst : clock, asynchronous active-high reset
//   tag      : source of the read issued this cycle (SRC_NONE if none)
//   vid_hit, p_hit, o_hit : decode of the tag in the last stage
// ---------------------------------------------------------------------------
module arb_tag_pipe
   import track_arb_pkg::*;
#(
   parameter int DEPTH = 3
)(
   input  logic clk,
   input  logic rst,
   input  src_t tag,
   output logic vid_hit,
   output logic p_hit,
   output logic o_hit
);

   src_t stage [DEPTH];

   // Reset empties the pipe so reads in flight at reset never produce a valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= SRC_NONE;
         end
      end else begin
         stage[0] <= tag;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign vid_hit = (stage[DEPTH-1] == SRC_VID);
   assign p_hit   = (stage[DEPTH-1] == SRC_PLAYER);
   assign o_hit   = (stage[DEPTH-1] == SRC_OPP);

endmodule

// File: rtl/track_mem_arbiter.sv
// ---------------------------------------------------------------------------
// track_mem_arbiter
// Shares one read-only track tile-map BRAM between video fetch (fixed
// priority, never stalled) and two kart physics lookups served round-robin
// in cycles video leaves free. Responses return with latency 1+READ_LAT+1.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   bus            : track_mem_arbiter_if.slave (requesters + BRAM port)
// Optional build macro TRACK_ARB_STATS_EN adds:
//   p_max_wait_out, o_max_wait_out : peak wait per physics requester
//   starve_flag_out                : sticky, a wait counter hit STARVE_MAX
// ---------------------------------------------------------------------------
module track_mem_arbiter
   import track_arb_pkg::*;
#(
   parameter int ADDR_W     = TRACK_ADDR_W,
   parameter int DATA_W     = TILE_W,
   parameter int READ_LAT   = 2,
   parameter int STARVE_MAX = 1023
)(
   input  logic clk_in,
   input  logic rst_in,
   track_mem_arbiter_if.slave bus
`ifdef TRACK_ARB_STATS_EN
   ,
   output logic [$clog2(STARVE_MAX+1)-1:0] p_max_wait_out,
   output logic [$clog2(STARVE_MAX+1)-1:0] o_max_wait_out,
   output logic                            starve_flag_out
`endif
);

   if (READ_LAT < 1 || READ_LAT > 4 || STARVE_MAX < 1) begin : g_param_check
      $error("track_mem_arbiter: READ_LAT must be 1..4 and STARVE_MAX >= 1");
   end

   logic              vid_gnt, p_gnt, o_gnt;
   src_t              issue_tag;
   src_t              rr_ptr, rr_next;
   logic [ADDR_W-1:0] issue_addr;
   logic [DATA_W-1:0] rd_data;
   logic              vid_hit, p_hit, o_hit;

   // Grant: video first, then a lone physics requester, then the round-robin
   // pointer. Depends only on req inputs and the pointer; nothing is granted
   // while reset is asserted so ready reads 0 during reset.
   always_comb begin
      vid_gnt = 1'b0;
      p_gnt   = 1'b0;
      o_gnt   = 1'b0;
      if (!rst_in) begin
         if (bus.vid_req_in) begin
            vid_gnt = 1'b1;
         end else if (bus.p_req_in && bus.o_req_in) begin
            if (rr_ptr == SRC_OPP) o_gnt = 1'b1;
            else                   p_gnt = 1'b1;
         end else begin
            p_gnt = bus.p_req_in;
            o_gnt = bus.o_req_in;
         end
      end
   end

   assign bus.p_ready_out = p_gnt;
   assign bus.o_ready_out = o_gnt;

   // Select the address and source tag of whichever requester won.
   always_comb begin
      issue_tag  = SRC_NONE;
      issue_addr = '0;
      if (vid_gnt) begin
         issue_tag  = SRC_VID;
         issue_addr = bus.vid_addr_in;
      end else if (p_gnt) begin
         issue_tag  = SRC_PLAYER;
         issue_addr = bus.p_addr_in;
      end else if (o_gnt) begin
         issue_tag  = SRC_OPP;
         issue_addr = bus.o_addr_in;
      end
   end

   // The pointer names who gets the next tie; it only moves on a physics grant.
   always_comb begin
      rr_next = rr_ptr;
      if (p_gnt) rr_next = SRC_OPP;
      if (o_gnt) rr_next = SRC_PLAYER;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) rr_ptr <= SRC_PLAYER;
      else        rr_ptr <= rr_next;
   end

   // BRAM address register holds its value when nothing is issued.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         bus.mem_addr_out <= '0;
      end else if (issue_tag != SRC_NONE) begin
         bus.mem_addr_out <= issue_addr;
      end
   end

   // One stage for the address register plus READ_LAT stages for the BRAM.
   arb_tag_pipe #(
      .DEPTH (1 + READ_LAT)
   ) u_tag_pipe (
      .clk     (clk_in),
      .rst     (rst_in),
      .tag     (issue_tag),
      .vid_hit (vid_hit),
      .p_hit   (p_hit),
      .o_hit   (o_hit)
   );

   assign rd_data = bus.mem_data_in;

   // Steer returning data; data outputs hold their last value between valids.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         bus.vid_valid_out <= 1'b0;
         bus.p_valid_out   <= 1'b0;
         bus.o_valid_out   <= 1'b0;
         bus.vid_data_out  <= '0;
         bus.p_data_out    <= '0;
         bus.o_data_out    <= '0;
      end else begin
         bus.vid_valid_out <= vid_hit;
         bus.p_valid_out   <= p_hit;
         bus.o_valid_out   <= o_hit;
         if (vid_hit) bus.vid_data_out <= rd_data;
         if (p_hit)   bus.p_data_out   <= rd_data;
         if (o_hit)   bus.o_data_out   <= rd_data;
      end
   end

`ifdef TRACK_ARB_STATS_EN
   localparam int              WAIT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(STARVE_MAX);

   logic [WAIT_W-1:0] p_wait, o_wait;

   // Wait counters count stalled cycles, saturate, and clear on acceptance;
   // the peak is captured at acceptance and the starve flag is sticky.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         p_wait          <= '0;
         o_wait          <= '0;
         p_max_wait_out  <= '0;
         o_max_wait_out  <= '0;
         starve_flag_out <= 1'b0;
      end else begin
         if (p_gnt)                                p_wait <= '0;
         else if (bus.p_req_in && p_wait != WAIT_LIM) p_wait <= p_wait + 1'b1;
         if (o_gnt)                                o_wait <= '0;
         else if (bus.o_req_in && o_wait != WAIT_LIM) o_wait <= o_wait + 1'b1;
         if (p_gnt && p_wait > p_max_wait_out) p_max_wait_out <= p_wait;
         if (o_gnt && o_wait > o_max_wait_out) o_max_wait_out <= o_wait;
         if (p_wait == WAIT_LIM || o_wait == WAIT_LIM) starve_flag_out <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_track_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_track_mem_arbiter
// Directed bench for track_mem_arbiter with a response scoreboard. A BRAM
// model returns addr[3:0] after two cycles. Stats checks are compiled in
// when TRACK_ARB_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_track_mem_arbiter;
   import track_arb_pkg::*;

   localparam int LAT = 4;

   typedef struct {
      src_t       src;
      logic [3:0] data;
      int         due;
   } exp_t;

   logic clk_in = 1'b0;
   logic rst_in;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t sb[$];

   logic [3:0] rd1, rd2;
   int         nval;
   src_t       mon_src;
   logic [3:0] mon_data;
   exp_t       mon_exp;

   always #5 clk_in = ~clk_in;

   track_mem_arbiter_if bus ();

`ifdef TRACK_ARB_STATS_EN
   logic [2:0] p_max_wait_out, o_max_wait_out;
   logic       starve_flag_out;
`endif

   track_mem_arbiter #(
      .ADDR_W     (14),
      .DATA_W     (4),
      .READ_LAT   (2),
      .STARVE_MAX (7)
   ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .bus             (bus)
`ifdef TRACK_ARB_STATS_EN
      ,
      .p_max_wait_out  (p_max_wait_out),
      .o_max_wait_out  (o_max_wait_out),
      .starve_flag_out (starve_flag_out)
`endif
   );

   // BRAM model: two-cycle read latency, tile code = low nibble of address.
   always @(posedge clk_in) begin
      rd1 <= bus.mem_addr_out[3:0];
      rd2 <= rd1;
   end
   assign bus.mem_data_in = rd2;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, required, cyc);
      end
   endtask

   task automatic expectResp(input src_t s, input logic [13:0] a);
      exp_t e;
      e.src  = s;
      e.data = a[3:0];
      e.due  = cyc + LAT;
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input logic v, input logic [13:0] va,
                                input logic p, input logic [13:0] pa,
                                input logic o, input logic [13:0] oa);
      bus.vid_req_in  = v;
      bus.vid_addr_in = va;
      bus.p_req_in    = p;
      bus.p_addr_in   = pa;
      bus.o_req_in    = o;
      bus.o_addr_in   = oa;
   endtask

   // One bus cycle: drive, check readies against hand-computed grants,
   // record the expected responses, then advance past the next edge.
   task automatic runCycle(input string name,
                           input logic v, input logic [13:0] va,
                           input logic p, input logic [13:0] pa,
                           input logic o, input logic [13:0] oa,
                           input logic ep, input logic eo);
      applyStimulus(v, va, p, pa, o, oa);
      #1;
      checkOutput({name, "_p_ready"}, {31'd0, bus.p_ready_out}, {31'd0, ep});
      checkOutput({name, "_o_ready"}, {31'd0, bus.o_ready_out}, {31'd0, eo});
      if (v)  expectResp(SRC_VID, va);
      if (ep) expectResp(SRC_PLAYER, pa);
      if (eo) expectResp(SRC_OPP, oa);
      @(posedge clk_in);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         runCycle("idle", 1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 1'b0);
      end
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, "_vid_valid"}, {31'd0, bus.vid_valid_out}, 0);
      checkOutput({name, "_p_valid"},   {31'd0, bus.p_valid_out}, 0);
      checkOutput({name, "_o_valid"},   {31'd0, bus.o_valid_out}, 0);
      checkOutput({name, "_p_ready"},   {31'd0, bus.p_ready_out}, 0);
      checkOutput({name, "_o_ready"},   {31'd0, bus.o_ready_out}, 0);
      checkOutput({name, "_mem_addr"},  {18'd0, bus.mem_addr_out}, 0);
      checkOutput({name, "_vid_data"},  {28'd0, bus.vid_data_out}, 0);
      checkOutput({name, "_p_data"},    {28'd0, bus.p_data_out}, 0);
      checkOutput({name, "_o_data"},    {28'd0, bus.o_data_out}, 0);
   endtask

   // Monitor: pops the scoreboard whenever any valid is presented and
   // checks source, data and arrival cycle; flags responses that never came.
   always @(negedge clk_in) begin
      if (rst_in) begin
         sb.delete();
      end else begin
         nval = int'(bus.vid_valid_out) + int'(bus.p_valid_out) + int'(bus.o_valid_out);
         if (nval > 1) checkOutput("one_valid", nval, 1);
         if (nval != 0) begin
            if (bus.vid_valid_out) begin
               mon_src  = SRC_VID;
               mon_data = bus.vid_data_out;
            end else if (bus.p_valid_out) begin
               mon_src  = SRC_PLAYER;
               mon_data = bus.p_data_out;
            end else begin
               mon_src  = SRC_OPP;
               mon_data = bus.o_data_out;
            end
            if (sb.size() == 0) begin
               checkOutput("unexpected_valid", mon_src, SRC_NONE);
            end else begin
               mon_exp = sb.pop_front();
               checkOutput("resp_src",   mon_src, mon_exp.src);
               checkOutput("resp_data",  mon_data, mon_exp.data);
               checkOutput("resp_cycle", cyc, mon_exp.due);
            end
         end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            mon_exp = sb.pop_front();
            checkOutput("resp_missing", SRC_NONE, mon_exp.src);
         end
      end
   end

   initial begin
      logic [13:0] pa_l [4];
      logic [13:0] oa_l [4];
      int pi, oi;
      logic exp_p;

      pa_l = '{14'h0011, 14'h0012, 14'h0013, 14'h0014};
      oa_l = '{14'h0025, 14'h0026, 14'h0027, 14'h0028};

      // Reset with every request asserted: nothing may be granted or valid.
      rst_in = 1'b1;
      applyStimulus(1'b1, 14'h1234, 1'b1, 14'h0ABC, 1'b1, 14'h0DEF);
      repeat (2) @(posedge clk_in);
      #1;
      checkAllZero("reset");
`ifdef TRACK_ARB_STATS_EN
      checkOutput("reset_starve", {31'd0, starve_flag_out}, 0);
      checkOutput("reset_p_max", {29'd0, p_max_wait_out}, 0);
`endif
      applyStimulus(1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 14'h0);
      rst_in = 1'b0;
      @(posedge clk_in);
      #1;

      // Fairness: both physics requesters held, first grant goes to player.
      pi = 0;
      oi = 0;
      for (int i = 0; i < 6; i++) begin
         exp_p = (i % 2 == 0);
         runCycle("fair", 1'b0, 14'h0, 1'b1, pa_l[pi], 1'b1, oa_l[oi], exp_p, !exp_p);
         if (exp_p) pi++;
         else       oi++;
      end
      idleCycles(6);

      // Latency: single video read of 0x0123 returns 0x3.
      runCycle("lat", 1'b1, 14'h0123, 1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 1'b0);
      idleCycles(6);

      // Video blocks player for 10 cycles; player wins the cycle video drops.
      for (int i = 0; i < 10; i++) begin
         runCycle("vblock", 1'b1, 14'h0100 + 14'(i), 1'b1, 14'h0ABC, 1'b0, 14'h0, 1'b0, 1'b0);
      end
      runCycle("vblock_go", 1'b0, 14'h0, 1'b1, 14'h0ABC, 1'b0, 14'h0, 1'b1, 1'b0);
      idleCycles(6);

      // Both physics stalled under video; pointer now favours opponent.
      for (int i = 0; i < 3; i++) begin
         runCycle("both_stall", 1'b1, 14'h0140 + 14'(i), 1'b1, 14'h0031, 1'b1, 14'h0042, 1'b0, 1'b0);
      end
      runCycle("both_o", 1'b0, 14'h0, 1'b1, 14'h0031, 1'b1, 14'h0042, 1'b0, 1'b1);
      runCycle("both_p", 1'b0, 14'h0, 1'b1, 14'h0031, 1'b0, 14'h0, 1'b1, 1'b0);
      idleCycles(6);

      // Mixed pipeline: V, P, V, O on consecutive cycles.
      runCycle("mix_v1", 1'b1, 14'h0201, 1'b1, 14'h0B0A, 1'b0, 14'h0, 1'b0, 1'b0);
      runCycle("mix_p",  1'b0, 14'h0,    1'b1, 14'h0B0A, 1'b0, 14'h0, 1'b1, 1'b0);
      runCycle("mix_v2", 1'b1, 14'h0207, 1'b0, 14'h0,    1'b0, 14'h0, 1'b0, 1'b0);
      runCycle("mix_o",  1'b0, 14'h0,    1'b0, 14'h0,    1'b1, 14'h0F0E, 1'b0, 1'b1);
      idleCycles(6);

      // Reset two cycles after a player accept: that read must never return.
      applyStimulus(1'b0, 14'h0, 1'b1, 14'h0D05, 1'b0, 14'h0);
      #1;
      checkOutput("rstmid_p_ready", {31'd0, bus.p_ready_out}, 1);
      @(posedge clk_in);
      #1;
      applyStimulus(1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 14'h0);
      repeat (2) begin
         @(posedge clk_in);
         #1;
      end
      rst_in = 1'b1;
      applyStimulus(1'b1, 14'h0333, 1'b1, 14'h0444, 1'b1, 14'h0555);
      #1;
      checkAllZero("rstmid");
      repeat (2) @(posedge clk_in);
      #1;
      applyStimulus(1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 14'h0);
      rst_in = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk_in);
         #1;
         checkOutput("rstmid_no_p_valid", {31'd0, bus.p_valid_out}, 0);
      end

`ifdef TRACK_ARB_STATS_EN
      // Video held 12 cycles with player pending: counter saturates at 7.
      for (int i = 0; i < 12; i++) begin
         runCycle("stat_wait", 1'b1, 14'h0300 + 14'(i), 1'b1, 14'h0005, 1'b0, 14'h0, 1'b0, 1'b0);
      end
      runCycle("stat_go", 1'b0, 14'h0, 1'b1, 14'h0005, 1'b0, 14'h0, 1'b1, 1'b0);
      checkOutput("stat_p_max", {29'd0, p_max_wait_out}, 7);
      checkOutput("stat_o_max", {29'd0, o_max_wait_out}, 0);
      checkOutput("stat_starve", {31'd0, starve_flag_out}, 1);
      idleCycles(6);
      checkOutput("stat_starve_sticky", {31'd0, starve_flag_out}, 1);
`endif

      checkOutput("sb_drain", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
